// File: rtl/sevseg_display_arbiter_if.sv
// Bus bundle for the seven-segment display arbiter: two requester
// handshakes, the blink enable, the Avalon-MM PIO write port and busy.
interface sevseg_display_arbiter_if;
  logic        req_a;
  logic [15:0] data_a;
  logic [3:0]  dp_a;
  logic        gnt_a;
  logic        req_b;
  logic [15:0] data_b;
  logic [3:0]  dp_b;
  logic        gnt_b;
  logic        blink_en;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic        busy;

  // Arbiter side: owns the grants, the PIO write strobe and busy.
  modport master (
    input  req_a, data_a, dp_a, req_b, data_b, dp_b, blink_en,
    output gnt_a, gnt_b, pio_address, pio_chipselect, pio_write_n,
           pio_writedata, busy
  );

  // Environment side: the two requesters and the PIO slave.
  modport slave (
    output req_a, data_a, dp_a, req_b, data_b, dp_b, blink_en,
    input  gnt_a, gnt_b, pio_address, pio_chipselect, pio_write_n,
           pio_writedata, busy
  );
endinterface

// File: rtl/sevseg_display_arbiter.sv
// Shares the 4-digit seven-segment PIO register between two round-robin
// requesters and a blink refresher. Each accepted 16-bit hex value is
// encoded into four segment bytes and written with a single-cycle
// Avalon-MM strobe at address 0. BLINK_DIV must be at least 8.
module sevseg_display_arbiter #(
  parameter int unsigned BLINK_DIV  = 25000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                            clk,
  input  logic                            reset,
  sevseg_display_arbiter_if.master        bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENC   = 2'd1,
    WRITE = 2'd2
  } state_t;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_t;

  localparam logic [31:0]      BLANK   = ACTIVE_LOW ? 32'hFFFF_FFFF : 32'h0000_0000;
  localparam int               CNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  // Hex nibble to {g,f,e,d,c,b,a}, lit segment = 1.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      4'hE:    seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  // Packs {dp, segments} per digit, digit 0 in the low byte.
  function automatic logic [31:0] encode(input logic [15:0] hex, input logic [3:0] dp);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 4; i++) begin
      w[i*8 +: 8] = {dp[i], seg7(hex[i*4 +: 4])};
    end
    return ACTIVE_LOW ? ~w : w;
  endfunction

  state_t           state, state_next;
  src_t             last_grant;
  logic             grant_a, grant_b;
  logic             gnt_a_q, gnt_b_q;
  logic [15:0]      cap_hex;
  logic [3:0]       cap_dp;
  logic             from_req;
  logic [31:0]      enc_word;
  logic [31:0]      stored_word;
  logic [31:0]      write_word;
  logic             wr_phase_blank;
  logic             pio_cs_q, pio_wr_n_q;
  logic [31:0]      pio_data_q;
  logic [CNT_W-1:0] blink_cnt, cnt_next;
  logic             phase_blank, phase_next, phase_event;
  logic             refresh_pending;

  assign enc_word           = encode(cap_hex, cap_dp);
  assign bus.gnt_a          = gnt_a_q;
  assign bus.gnt_b          = gnt_b_q;
  assign bus.pio_address    = 2'b00;
  assign bus.pio_chipselect = pio_cs_q;
  assign bus.pio_write_n    = pio_wr_n_q;
  assign bus.pio_writedata  = pio_data_q;
  assign bus.busy           = (state != IDLE);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Round-robin arbitration and next-state; requesters beat a pending refresh.
  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned and a latch is never inferred.
  always_comb begin
    state_next = state;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_a && (!bus.req_b || last_grant == SRC_B)) grant_a = 1'b1;
        else if (bus.req_b)                                    grant_b = 1'b1;
        if (grant_a || grant_b || refresh_pending) state_next = ENC;
      end
      ENC:     state_next = WRITE;
      WRITE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Blink divider: counter wraps at BLINK_DIV, phase returns to visible when disabled.
  always_comb begin
    cnt_next    = blink_cnt;
    phase_next  = phase_blank;
    phase_event = 1'b0;
    if (bus.blink_en) begin
      if (blink_cnt == CNT_MAX) begin
        cnt_next    = '0;
        phase_next  = ~phase_blank;
        phase_event = 1'b1;
      end else begin
        cnt_next = blink_cnt + CNT_W'(1);
      end
    end else begin
      cnt_next = '0;
      if (phase_blank) begin
        phase_next  = 1'b0;
        phase_event = 1'b1;
      end
    end
  end

  // Grant pulses and capture of the winning requester's value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      last_grant <= SRC_B;
      cap_hex    <= '0;
      cap_dp     <= '0;
      from_req   <= 1'b0;
    end else begin
      gnt_a_q <= grant_a;
      gnt_b_q <= grant_b;
      if (grant_a || grant_b) begin
        last_grant <= grant_a ? SRC_A : SRC_B;
        cap_hex    <= grant_a ? bus.data_a : bus.data_b;
        cap_dp     <= grant_a ? bus.dp_a   : bus.dp_b;
      end
      if (state == IDLE) from_req <= grant_a || grant_b;
    end
  end

  // Blink counter and phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      phase_blank <= 1'b0;
    end else begin
      blink_cnt   <= cnt_next;
      phase_blank <= phase_next;
    end
  end

  // Encode/write pipeline, PIO strobe and refresh bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stored_word     <= BLANK;
      write_word      <= BLANK;
      wr_phase_blank  <= 1'b0;
      pio_cs_q        <= 1'b0;
      pio_wr_n_q      <= 1'b1;
      pio_data_q      <= '0;
      refresh_pending <= 1'b1;
    end else begin
      pio_cs_q   <= 1'b0;
      pio_wr_n_q <= 1'b1;
      if (state == ENC) begin
        if (from_req) stored_word <= enc_word;
        write_word     <= phase_blank ? BLANK : (from_req ? enc_word : stored_word);
        wr_phase_blank <= phase_blank;
      end
      if (state == WRITE) begin
        pio_cs_q   <= 1'b1;
        pio_wr_n_q <= 1'b0;
        pio_data_q <= write_word;
        // The write is current unless the phase moved after it was encoded,
        // in which case one more refresh is owed.
        refresh_pending <= (phase_next != wr_phase_blank);
      end else if (phase_event) begin
        refresh_pending <= 1'b1;
      end
    end
  end

endmodule

// File: doc/sevseg_display_arbiter.md
Name: sevseg_display_arbiter

Overview:
- Shares the 4-digit seven-segment PIO output register between two hardware requesters and an internal blink refresher.
- Arbitrates the requesters round-robin and converts each 16-bit hex value into segment codes.
- Issues single-cycle Avalon-MM write strobes to the PIO slave at address 0.
- Sits between the photo-pipeline status sources and the seven-segment PIO on the system interconnect.

Parameters:
- BLINK_DIV, 25000000: clock cycles per blink half-period. Must be at least 8.
- ACTIVE_LOW, 1: when 1, each packed byte is inverted, so a lit segment is driven as 0.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_a  in  1  requester A write request, level, held until granted
- data_a  in  16  requester A hex value; digit0 = [3:0]
- dp_a  in  4  requester A decimal points, one bit per digit
- gnt_a  out  1  one-cycle grant pulse for requester A
- req_b  in  1  requester B write request
- data_b  in  16  requester B hex value
- dp_b  in  4  requester B decimal points
- gnt_b  out  1  one-cycle grant pulse for requester B
- blink_en  in  1  enables blinking of the display
- pio_address  out  2  PIO address, always 0
- pio_chipselect  out  1  PIO chipselect
- pio_write_n  out  1  PIO write, active-low
- pio_writedata  out  32  packed segment word
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values (asynchronous, take effect immediately):
  - state = IDLE; gnt_a = gnt_b = 0; pio_chipselect = 0; pio_write_n = 1; pio_address = 0; pio_writedata = 0.
  - stored word = BLANK; blink counter = 0; phase = visible; last_grant = B; refresh_pending = 1.
  - An in-flight write strobe is dropped at once; no partial write is issued.
- Encoding:
  - Nibble to {g,f,e,d,c,b,a}: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
  - Byte i = {dp[i], seg(nibble i)}, inverted when ACTIVE_LOW = 1.
  - Word = {byte3, byte2, byte1, byte0}.
  - BLANK = all segments and decimal points off: FFFFFFFF when ACTIVE_LOW = 1, 00000000 when ACTIVE_LOW = 0.
- State machine:
  - States are IDLE -> ENC -> WRITE -> IDLE.
  - In IDLE, a requester takes priority over a pending refresh.
  - If only one requester is active, it wins.
  - If both are active, the one not equal to last_grant wins.
  - At the granting edge: the winner's data and dp are captured, gnt_x goes high for exactly one cycle, last_grant is updated, and state becomes ENC.
  - If no requester is active and refresh_pending = 1, state goes to ENC with no grant.
  - ENC registers the encoded word into the stored word (requester source only). It then registers write_word = phase_blank ? BLANK : stored word.
  - WRITE holds pio_chipselect = 1, pio_write_n = 0, pio_writedata = write_word for exactly one cycle. refresh_pending is cleared at this edge.
  - Next cycle: strobe deasserted, state = IDLE. pio_writedata holds its last value.
- Latency: req sampled in IDLE at edge N; gnt high during cycle N..N+1; write strobe high during cycle N+2..N+3. Minimum spacing between writes is 3 cycles.
- Requester rules:
  - The requester must drop req in the cycle after it sees gnt; a still-high req is treated as a new request.
  - Requests arriving while busy are held, not lost, because req is level.
- Blink:
  - While blink_en = 1, the counter runs 0..BLINK_DIV-1 and wraps.
  - On wrap, phase toggles and refresh_pending is set.
  - While blink_en = 0, the counter is held at 0.
  - If blink_en falls while phase = blank: phase returns to visible and refresh_pending is set, so the display is restored.
- Simultaneous events:
  - A refresh and a request in the same cycle: the request is served first. refresh_pending stays set unless the requester write itself carries the current phase, in which case it is cleared at that WRITE.
  - A wrap occurring during ENC/WRITE re-sets refresh_pending after the WRITE clears it, giving one more write.

Test Plan:
- Reset release, ACTIVE_LOW = 1 -> first write occurs within 3 cycles with writedata FFFFFFFF; no gnt pulses.
- req_a with data_a = 1234 and dp_a = 0 -> gnt_a one cycle; strobe 2 cycles later; writedata F9A4B099; address 0.
- req_a and req_b asserted together and held (A = 1111, B = 2222), each dropping req after its own gnt -> order is A then B. Writes are F9F9F9F9 then A4A4A4A4, exactly 3 cycles apart.
- BLINK_DIV = 8, blink_en = 1 after storing 1234 -> writes alternate FFFFFFFF / F9A4B099, one every 8 cycles.
- blink_en dropped during blank phase -> one write of F9A4B099 follows.
- Reset asserted in the WRITE cycle -> chipselect drops immediately; after release, a blank write occurs.
